// File: rtl/generator_stream_driver.sv
// rtl/generator_stream_driver.sv - seed fill / feature drain host driver for the generator pipeline
// Fills the seed FIFO from a Galois LFSR, handshakes the pipeline, then drains features to a stream.
module generator_stream_driver #(
   parameter int SEED_COUNT    = 64,
   parameter int FEATURE_COUNT = 128,
   parameter int TIMEOUT_W     = 24
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        go,
   input  logic        continuous,
   input  logic [15:0] lfsr_init,
   output logic        seed_wr_en,
   output logic [15:0] seed_wr_data,
   input  logic        seed_full,
   input  logic [6:0]  seed_level,
   output logic        gen_start,
   input  logic        gen_busy,
   input  logic        gen_done,
   output logic        feature_rd_en,
   input  logic [15:0] feature_rd_data,
   input  logic        feature_rd_valid,
   input  logic        feature_empty,
   input  logic [7:0]  feature_level,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_data,
   output logic        out_last,
   output logic        busy,
   output logic        frame_done,
   output logic [15:0] frame_count,
   output logic        timeout_err
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FILL  = 3'd1;
   localparam logic [2:0] S_START = 3'd2;
   localparam logic [2:0] S_WAIT  = 3'd3;
   localparam logic [2:0] S_DRAIN = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   localparam int SC_W = $clog2(SEED_COUNT + 1);
   localparam int FC_W = $clog2(FEATURE_COUNT + 1);
   localparam logic [SC_W-1:0]      SEED_LAST = SC_W'(SEED_COUNT - 1);
   localparam logic [6:0]           SEED_LVL  = 7'(SEED_COUNT);
   localparam logic [FC_W-1:0]      FEAT_ALL  = FC_W'(FEATURE_COUNT);
   localparam logic [FC_W-1:0]      FEAT_LAST = FC_W'(FEATURE_COUNT - 1);
   localparam logic [TIMEOUT_W-1:0] WDOG_MAX  = {TIMEOUT_W{1'b1}};

   logic [2:0]           state_q, state_d;
   logic [15:0]          lfsr_q, lfsr_d;
   logic [SC_W-1:0]      seed_cnt_q, seed_cnt_d;
   logic                 start_held_q, start_held_d;
   logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
   logic [FC_W-1:0]      rd_cnt_q, rd_cnt_d;
   logic [FC_W-1:0]      acc_cnt_q, acc_cnt_d;
   logic                 inflight_q, inflight_d;
   logic [15:0]          buf0_q, buf0_d;
   logic [15:0]          buf1_q, buf1_d;
   logic [1:0]           buf_cnt_q, buf_cnt_d;
   logic [15:0]          frame_count_q, frame_count_d;
   logic                 timeout_err_q, timeout_err_d;

   logic [15:0] lfsr_next;
   logic        push;
   logic        pop;
   logic        unused_feature_level;

   assign unused_feature_level = ^feature_level;
   assign lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

   assign seed_wr_en    = (state_q == S_FILL) && !seed_full;
   assign seed_wr_data  = seed_wr_en ? lfsr_q : 16'h0000;
   assign gen_start     = (state_q == S_START) &&
                          (start_held_q || ((seed_level >= SEED_LVL) && feature_empty));
   assign out_valid     = (state_q == S_DRAIN) && (buf_cnt_q != 2'd0);
   assign out_data      = out_valid ? buf0_q : 16'h0000;
   assign out_last      = out_valid && (acc_cnt_q == FEAT_LAST);
   assign pop           = out_valid && out_ready;
   assign push          = feature_rd_valid && inflight_q;
   // A word leaving this cycle frees its slot, which keeps the drain at one word per cycle.
   assign feature_rd_en = (state_q == S_DRAIN) && !feature_empty && (rd_cnt_q < FEAT_ALL) &&
                          (({1'b0, buf_cnt_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));
   assign busy          = (state_q != S_IDLE);
   assign frame_done    = (state_q == S_DONE);
   assign frame_count   = frame_count_q;
   assign timeout_err   = timeout_err_q;

   always_comb begin
      state_d       = state_q;
      lfsr_d        = lfsr_q;
      seed_cnt_d    = seed_cnt_q;
      start_held_d  = start_held_q;
      wdog_d        = wdog_q;
      rd_cnt_d      = rd_cnt_q;
      acc_cnt_d     = acc_cnt_q;
      inflight_d    = feature_rd_en;
      buf0_d        = buf0_q;
      buf1_d        = buf1_q;
      buf_cnt_d     = buf_cnt_q;
      frame_count_d = frame_count_q;
      timeout_err_d = timeout_err_q;

      if (push && pop) begin
         if (buf_cnt_q == 2'd2) begin
            buf0_d = buf1_q;
            buf1_d = feature_rd_data;
         end else begin
            buf0_d = feature_rd_data;
         end
      end else if (pop) begin
         buf0_d    = buf1_q;
         buf_cnt_d = buf_cnt_q - 2'd1;
      end else if (push) begin
         if (buf_cnt_q == 2'd0) begin
            buf0_d = feature_rd_data;
         end else begin
            buf1_d = feature_rd_data;
         end
         buf_cnt_d = buf_cnt_q + 2'd1;
      end

      case (state_q)
         S_IDLE: begin
            if (go) begin
               lfsr_d        = (lfsr_init == 16'h0000) ? 16'hACE1 : lfsr_init;
               timeout_err_d = 1'b0;
               seed_cnt_d    = '0;
               buf_cnt_d     = 2'd0;
               state_d       = S_FILL;
            end
         end
         S_FILL: begin
            if (seed_wr_en) begin
               lfsr_d     = lfsr_next;
               seed_cnt_d = seed_cnt_q + SC_W'(1);
               if (seed_cnt_q == SEED_LAST) begin
                  state_d      = S_START;
                  wdog_d       = '0;
                  start_held_d = 1'b0;
                  rd_cnt_d     = '0;
                  acc_cnt_d    = '0;
               end
            end
         end
         S_START: begin
            wdog_d = wdog_q + TIMEOUT_W'(1);
            if (gen_start) begin
               start_held_d = 1'b1;
            end
            if (gen_start && gen_busy) begin
               state_d = S_WAIT;
            end
            if (wdog_q == WDOG_MAX) begin
               timeout_err_d = 1'b1;
               state_d       = S_IDLE;
            end
         end
         S_WAIT: begin
            wdog_d = wdog_q + TIMEOUT_W'(1);
            if (gen_done) begin
               state_d = S_DRAIN;
            end else if (wdog_q == WDOG_MAX) begin
               timeout_err_d = 1'b1;
               state_d       = S_IDLE;
            end
         end
         S_DRAIN: begin
            if (feature_rd_en) begin
               rd_cnt_d = rd_cnt_q + FC_W'(1);
            end
            if (pop) begin
               acc_cnt_d = acc_cnt_q + FC_W'(1);
               if (out_last) begin
                  state_d = S_DONE;
               end
            end
         end
         S_DONE: begin
            frame_count_d = frame_count_q + 16'd1;
            if (continuous && go) begin
               seed_cnt_d = '0;
               state_d    = S_FILL;
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         lfsr_q        <= 16'h0000;
         seed_cnt_q    <= '0;
         start_held_q  <= 1'b0;
         wdog_q        <= '0;
         rd_cnt_q      <= '0;
         acc_cnt_q     <= '0;
         inflight_q    <= 1'b0;
         buf0_q        <= 16'h0000;
         buf1_q        <= 16'h0000;
         buf_cnt_q     <= 2'd0;
         frame_count_q <= 16'h0000;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         lfsr_q        <= lfsr_d;
         seed_cnt_q    <= seed_cnt_d;
         start_held_q  <= start_held_d;
         wdog_q        <= wdog_d;
         rd_cnt_q      <= rd_cnt_d;
         acc_cnt_q     <= acc_cnt_d;
         inflight_q    <= inflight_d;
         buf0_q        <= buf0_d;
         buf1_q        <= buf1_d;
         buf_cnt_q     <= buf_cnt_d;
         frame_count_q <= frame_count_d;
         timeout_err_q <= timeout_err_d;
      end
   end

endmodule

// File: tb/tb_generator_stream_driver.sv
// tb/tb_generator_stream_driver.sv - scoreboard bench with a seed/feature FIFO pipeline model
// Stimulus pushes expected seeds/words; negedge monitors pop and compare.
module tb_generator_stream_driver;

   logic        clk = 1'b0;
   logic        rst_n, go, continuous, out_ready;
   logic [15:0] lfsr_init;
   logic        seed_wr_en, seed_full, gen_start, feature_rd_en;
   logic [15:0] seed_wr_data, out_data, frame_count;
   logic [6:0]  seed_level;
   logic        gen_busy = 1'b0, gen_done = 1'b0, feature_rd_valid = 1'b0;
   logic [15:0] feature_rd_data = 16'h0000;
   logic        feature_empty;
   logic [7:0]  feature_level;
   logic        out_valid, out_last, busy, frame_done, timeout_err;

   always #5 clk = ~clk;

   generator_stream_driver #(.SEED_COUNT(64), .FEATURE_COUNT(128), .TIMEOUT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .go(go), .continuous(continuous), .lfsr_init(lfsr_init),
      .seed_wr_en(seed_wr_en), .seed_wr_data(seed_wr_data), .seed_full(seed_full),
      .seed_level(seed_level), .gen_start(gen_start), .gen_busy(gen_busy), .gen_done(gen_done),
      .feature_rd_en(feature_rd_en), .feature_rd_data(feature_rd_data),
      .feature_rd_valid(feature_rd_valid), .feature_empty(feature_empty),
      .feature_level(feature_level), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last), .busy(busy), .frame_done(frame_done),
      .frame_count(frame_count), .timeout_err(timeout_err)
   );

   int tests_run = 0, tests_failed = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [15:0] exp_seed[$];
   logic [16:0] exp_out[$];
   logic [15:0] seed_log[$];
   logic [15:0] fq[$];

   int   seed_cnt_m = 0, fcnt = 0, start_cnt = 0, start_cyc = 0;
   logic force_full = 1'b0, pipe_hang = 1'b0, pipe_abort = 1'b0;
   assign seed_full     = (seed_cnt_m >= 64) || force_full;
   assign seed_level    = 7'(seed_cnt_m);
   assign feature_empty = (fcnt == 0);
   assign feature_level = 8'(fcnt);

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
   endfunction

   // Pipeline model: samples DUT strobes at negedge, applies their effect just after the next posedge.
   initial begin
      logic s_rst, s_wr, s_rd, s_gs, s_hang, s_abort;
      int   s_cyc, p_state, p_timer;
      logic [7:0] frame_tag;
      p_state = 0; p_timer = 0; frame_tag = 8'h10;
      forever begin
         @(negedge clk);
         s_rst = rst_n; s_wr = seed_wr_en; s_rd = feature_rd_en; s_gs = gen_start;
         s_hang = pipe_hang; s_abort = pipe_abort; s_cyc = cyc;
         @(posedge clk);
         #1;
         gen_done = 1'b0;
         if (!s_rst) begin
            seed_cnt_m = 0; fq.delete(); gen_busy = 1'b0; feature_rd_valid = 1'b0; p_state = 0;
         end else begin
            if (s_wr) seed_cnt_m++;
            feature_rd_valid = s_rd;
            if (s_rd && fq.size() > 0) feature_rd_data = fq.pop_front();
            case (p_state)
               0: if (s_gs) begin
                  gen_busy = 1'b1; start_cnt++; start_cyc = s_cyc;
                  p_state = s_hang ? 2 : 1; p_timer = 20;
               end
               1: begin
                  p_timer--;
                  if (p_timer == 0) begin
                     seed_cnt_m = 0;
                     for (int k = 0; k < 128; k++) begin
                        fq.push_back({frame_tag, 8'(k)});
                        exp_out.push_back({(k == 127), frame_tag, 8'(k)});
                     end
                     frame_tag = frame_tag + 8'h01;
                     gen_done = 1'b1; gen_busy = 1'b0; p_state = 0;
                  end
               end
               default: if (s_abort) begin
                  gen_busy = 1'b0; seed_cnt_m = 0; p_state = 0;
               end
            endcase
         end
         fcnt = fq.size();
      end
   end

   int   sw_cnt = 0, out_cnt = 0, last_cnt = 0, done_cnt = 0, outstanding = 0;
   int   first_pop_cyc = 0, last_pop_cyc = 0;
   logic prev_hold = 1'b0, prev_done = 1'b0;
   logic [15:0] prev_data = 16'h0000;

   always @(negedge clk) begin
      logic [16:0] e;
      if (!rst_n) begin
         outstanding = 0; prev_hold = 1'b0; prev_done = 1'b0;
      end else begin
         if (seed_wr_en) begin
            check("seed_wr_while_full", 32'(seed_full), 32'd0);
            check("seed_expected", 32'(exp_seed.size() != 0), 32'd1);
            if (exp_seed.size() != 0) check("seed_data", 32'(seed_wr_data), 32'(exp_seed.pop_front()));
            seed_log.push_back(seed_wr_data);
            sw_cnt++;
         end
         if (prev_hold) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'(out_data), 32'(prev_data));
         end
         prev_hold = out_valid && !out_ready;
         prev_data = out_data;
         if (out_valid && out_ready) begin
            check("out_expected", 32'(exp_out.size() != 0), 32'd1);
            if (exp_out.size() != 0) begin
               e = exp_out.pop_front();
               check("out_data", 32'(out_data), 32'(e[15:0]));
               check("out_last", 32'(out_last), 32'(e[16]));
            end
            out_cnt++;
            if (out_last) last_cnt++;
            if (out_cnt == 1) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
         end
         outstanding = outstanding + (feature_rd_en ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
         if (feature_rd_en) check("occupancy_le_2", 32'(outstanding <= 2), 32'd1);
         if (frame_done) begin
            done_cnt++;
            check("frame_done_width", 32'(prev_done), 32'd0);
         end
         prev_done = frame_done;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_seeds(input logic [15:0] init, input int n);
      logic [15:0] l;
      l = (init == 16'h0000) ? 16'hACE1 : init;
      for (int i = 0; i < n; i++) begin
         exp_seed.push_back(l);
         l = lfsr_step(l);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      exp_seed.delete(); exp_out.delete();
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      seed_log.delete();
      out_cnt = 0; last_cnt = 0;
   endtask

   task automatic begin_frame(input logic [15:0] init, input int nseeds);
      lfsr_init = init; go = 1'b1;
      push_seeds(init, nseeds);
      tick();
   endtask

   task automatic wait_done(input int target, input bit toggle, input int budget);
      int n;
      n = 0;
      while (done_cnt < target && n < budget) begin
         tick();
         if (toggle) out_ready = ~out_ready;
         n++;
      end
      check("frame_done_reached", 32'(done_cnt >= target), 32'd1);
      out_ready = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL sim_timeout: got no finish, expected finish before time limit");
      $fatal(1, "time limit");
   end

   initial begin
      int sw0, st0, d0, n, dt;
      rst_n = 1'b0; go = 1'b0; continuous = 1'b0; lfsr_init = 16'h0000; out_ready = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_seed_wr_en", 32'(seed_wr_en), 32'd0);
      check("rst_seed_wr_data", 32'(seed_wr_data), 32'd0);
      check("rst_gen_start", 32'(gen_start), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_frame_count", 32'(frame_count), 32'd0);
      check("rst_timeout_err", 32'(timeout_err), 32'd0);

      // Single frame, init 0001, ready held high
      do_reset();
      out_ready = 1'b1; sw0 = sw_cnt; st0 = start_cnt; d0 = done_cnt;
      begin_frame(16'h0001, 64);
      @(negedge clk);
      check("first_write_latency", 32'(seed_wr_en), 32'd1);
      tick();
      go = 1'b0;
      wait_done(d0 + 1, 1'b0, 2000);
      tick(); tick();
      check("t1_seed_writes", 32'(sw_cnt - sw0), 32'd64);
      check("t1_seed0", 32'(seed_log[0]), 32'h0001);
      check("t1_seed1", 32'(seed_log[1]), 32'hB400);
      check("t1_seed2", 32'(seed_log[2]), 32'h5A00);
      check("t1_seed12", 32'(seed_log[12]), 32'hB416);
      check("t1_gen_starts", 32'(start_cnt - st0), 32'd1);
      check("t1_out_words", 32'(out_cnt), 32'd128);
      check("t1_last_count", 32'(last_cnt), 32'd1);
      check("t1_throughput_span", 32'(last_pop_cyc - first_pop_cyc), 32'd127);
      check("t1_frame_count", 32'(frame_count), 32'd1);
      check("t1_idle", 32'(busy), 32'd0);
      check("t1_out_drained", 32'(exp_out.size()), 32'd0);

      // Ready toggling every cycle during drain
      do_reset();
      d0 = done_cnt;
      begin_frame(16'h1234, 64);
      go = 1'b0;
      wait_done(d0 + 1, 1'b1, 4000);
      tick();
      check("t2_out_words", 32'(out_cnt), 32'd128);
      check("t2_last_count", 32'(last_cnt), 32'd1);
      check("t2_frame_count", 32'(frame_count), 32'd1);
      check("t2_out_drained", 32'(exp_out.size()), 32'd0);

      // Seed FIFO full for 10 cycles mid-fill
      do_reset();
      sw0 = sw_cnt; d0 = done_cnt;
      begin_frame(16'hBEEF, 64);
      go = 1'b0;
      repeat (20) tick();
      n = sw_cnt;
      force_full = 1'b1;
      repeat (10) tick();
      check("t3_no_writes_in_stall", 32'(sw_cnt - n), 32'd0);
      force_full = 1'b0;
      wait_done(d0 + 1, 1'b0, 2000);
      check("t3_seed_writes", 32'(sw_cnt - sw0), 32'd64);
      check("t3_seeds_consumed", 32'(exp_seed.size()), 32'd0);

      // Continuous mode, two frames back to back
      do_reset();
      sw0 = sw_cnt; d0 = done_cnt; continuous = 1'b1;
      begin_frame(16'h0ACE, 128);
      wait_done(d0 + 1, 1'b0, 2000);
      @(negedge clk);
      check("t4_refill_after_done", 32'(seed_wr_en), 32'd1);
      check("t4_busy_after_done", 32'(busy), 32'd1);
      tick();
      go = 1'b0; continuous = 1'b0;
      wait_done(d0 + 2, 1'b0, 2000);
      tick(); tick();
      check("t4_frame_count", 32'(frame_count), 32'd2);
      check("t4_seed_writes", 32'(sw_cnt - sw0), 32'd128);
      check("t4_out_words", 32'(out_cnt), 32'd256);
      check("t4_idle", 32'(busy), 32'd0);

      // Pipeline never finishes: watchdog with TIMEOUT_W=8
      do_reset();
      d0 = done_cnt; pipe_hang = 1'b1;
      begin_frame(16'h0005, 64);
      go = 1'b0;
      n = 0;
      while (!timeout_err && n < 1000) begin
         tick();
         n++;
      end
      dt = cyc - start_cyc;
      check("t5_timeout_set", 32'(timeout_err), 32'd1);
      tests_run++;
      if (dt < 250 || dt > 262) begin
         tests_failed++;
         $display("FAIL t5_timeout_latency: got %0d cycles, expected 250..262", dt);
      end
      check("t5_idle_after_timeout", 32'(busy), 32'd0);
      repeat (5) tick();
      check("t5_timeout_sticky", 32'(timeout_err), 32'd1);
      check("t5_no_frame_done", 32'(done_cnt - d0), 32'd0);
      pipe_hang = 1'b0; pipe_abort = 1'b1;
      tick();
      pipe_abort = 1'b0;
      tick();
      begin_frame(16'h0001, 64);
      check("t5_go_clears_timeout", 32'(timeout_err), 32'd0);
      go = 1'b0;
      wait_done(d0 + 1, 1'b0, 2000);
      tick();
      check("t5_frame_count", 32'(frame_count), 32'd1);

      // Reset in the middle of drain, then a zero LFSR seed
      out_cnt = 0;
      begin_frame(16'h4321, 64);
      go = 1'b0;
      n = 0;
      while (out_cnt < 10 && n < 2000) begin
         tick();
         n++;
      end
      check("t6_reached_drain", 32'(out_cnt >= 10), 32'd1);
      rst_n = 1'b0;
      #1;
      check("t6_rst_seed_wr_en", 32'(seed_wr_en), 32'd0);
      check("t6_rst_gen_start", 32'(gen_start), 32'd0);
      check("t6_rst_rd_en", 32'(feature_rd_en), 32'd0);
      check("t6_rst_out_valid", 32'(out_valid), 32'd0);
      check("t6_rst_out_data", 32'(out_data), 32'd0);
      check("t6_rst_out_last", 32'(out_last), 32'd0);
      check("t6_rst_busy", 32'(busy), 32'd0);
      check("t6_rst_frame_count", 32'(frame_count), 32'd0);
      exp_out.delete(); exp_seed.delete();
      tick();
      rst_n = 1'b1;
      tick(); tick();
      seed_log.delete(); out_cnt = 0; d0 = done_cnt;
      begin_frame(16'h0000, 64);
      go = 1'b0;
      wait_done(d0 + 1, 1'b0, 2000);
      tick();
      check("t6_seed0_ace1", 32'(seed_log[0]), 32'hACE1);
      check("t6_out_words", 32'(out_cnt), 32'd128);
      check("t6_frame_count", 32'(frame_count), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
